dvfs_governor: RTL and testbench

DVFS_GOVERNOR -- requirements
Module: dvfs_governor

---
 rtl/dvfs_governor_if.sv | 32 +++
 rtl/dvfs_governor.sv | 150 +++++++++++++++
 tb/tb_dvfs_governor.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dvfs_governor_if.sv
// Governor <-> regulator/frequency-controller signal bundle.
// slave = governor side; master = the side driving utilization, acks and status.
interface dvfs_governor_if;
  logic       governor_enable;
  logic       util_valid;
  logic [7:0] util_sample;
  logic [2:0] max_level;
  logic       volt_req_valid;
  logic [2:0] volt_level_req;
  logic       volt_ack;
  logic [2:0] frequency_level_req;
  logic       frequency_enable;
  logic       frequency_ready;
  logic [2:0] current_frequency_level;
  logic       busy;
  logic [7:0] window_avg;
  logic       timeout_err;

  modport master (
    output governor_enable, util_valid, util_sample, max_level,
           volt_ack, frequency_ready, current_frequency_level,
    input  volt_req_valid, volt_level_req, frequency_level_req,
           frequency_enable, busy, window_avg, timeout_err
  );

  modport slave (
    input  governor_enable, util_valid, util_sample, max_level,
           volt_ack, frequency_ready, current_frequency_level,
    output volt_req_valid, volt_level_req, frequency_level_req,
           frequency_enable, busy, window_avg, timeout_err
  );
endinterface

// File: rtl/dvfs_governor.sv
// DVFS governor: windowed utilization average drives one-step level changes with volt-before-freq ordering.
// Decision one cycle after a window closes; requests held until ack/ready or timeout, then a fixed holdoff.
module dvfs_governor #(
  parameter int         WINDOW_LOG2    = 4,
  parameter logic [7:0] UP_THRESH      = 8'd192,
  parameter logic [7:0] DOWN_THRESH    = 8'd64,
  parameter logic [15:0] HOLDOFF_CYCLES = 16'd256,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic ref_clk,
  input  logic rst_n,
  dvfs_governor_if.slave bus
);

  typedef enum logic [2:0] {IDLE, VOLT_UP, FREQ_WAIT, VOLT_DOWN, HOLDOFF} state_t;

  state_t state, state_next;

  logic [8+WINDOW_LOG2-1:0] acc, acc_sum;
  logic [WINDOW_LOG2-1:0]   sample_cnt;
  logic                     window_done;
  logic [7:0]               avg_q;

  logic [2:0]  committed, target, target_next, vlr_q, pick;
  logic [15:0] cnt;
  logic        timeout_q, timeout_fire, freq_done;

  // Window accumulator
  assign acc_sum = acc + {{WINDOW_LOG2{1'b0}}, bus.util_sample};

  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      acc         <= '0;
      sample_cnt  <= '0;
      avg_q       <= '0;
      window_done <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (bus.util_valid) begin
        sample_cnt <= sample_cnt + 1'b1;
        if (sample_cnt == '1) begin
          avg_q       <= acc_sum[WINDOW_LOG2 +: 8];
          acc         <= '0;
          window_done <= 1'b1;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  assign freq_done = (state == FREQ_WAIT) && bus.frequency_ready &&
                     (bus.current_frequency_level == target);

  // State register and transition-scoped datapath
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      committed <= 3'd4;
      target    <= 3'd4;
      vlr_q     <= 3'd4;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state  <= state_next;
      target <= target_next;
      // One counter serves both the handshake timeout and the holdoff; it restarts on every state change.
      if (state_next != state || state == IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;
      if (freq_done)
        committed <= target;
      if (state_next == VOLT_UP || state_next == VOLT_DOWN)
        vlr_q <= target_next;
      if (timeout_fire)
        timeout_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next   = state;
    target_next  = target;
    timeout_fire = 1'b0;
    pick         = committed;

    if (committed > bus.max_level)
      pick = bus.max_level;
    else if (avg_q >= UP_THRESH && committed < bus.max_level)
      pick = committed + 3'd1;
    else if (avg_q <= DOWN_THRESH && committed != 3'd0)
      pick = committed - 3'd1;

    case (state)
      IDLE: begin
        if (window_done && bus.governor_enable) begin
          if (pick > committed) begin
            state_next  = VOLT_UP;
            target_next = pick;
          end else if (pick < committed) begin
            state_next  = FREQ_WAIT;
            target_next = pick;
          end
        end
      end
      VOLT_UP: begin
        if (bus.volt_ack) begin
          state_next = FREQ_WAIT;
        end else if (cnt == TIMEOUT_CYCLES - 16'd1) begin
          state_next   = HOLDOFF;
          timeout_fire = 1'b1;
        end
      end
      FREQ_WAIT: begin
        if (freq_done) begin
          state_next = (target < committed) ? VOLT_DOWN : HOLDOFF;
        end else if (cnt == TIMEOUT_CYCLES - 16'd1) begin
          state_next   = HOLDOFF;
          timeout_fire = 1'b1;
        end
      end
      VOLT_DOWN: begin
        if (bus.volt_ack) begin
          state_next = HOLDOFF;
        end else if (cnt == TIMEOUT_CYCLES - 16'd1) begin
          state_next   = HOLDOFF;
          timeout_fire = 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt == HOLDOFF_CYCLES - 16'd1)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy                = (state != IDLE);
    bus.volt_req_valid      = (state == VOLT_UP) || (state == VOLT_DOWN);
    bus.volt_level_req      = vlr_q;
    bus.frequency_enable    = (state == FREQ_WAIT);
    bus.frequency_level_req = (state == FREQ_WAIT) ? target : committed;
    bus.window_avg          = avg_q;
    bus.timeout_err         = timeout_q;
  end

endmodule

// File: tb/tb_dvfs_governor.sv
// Directed scoreboard bench for dvfs_governor: raise, lower, cap, discard, timeout and reset cases.
module tb_dvfs_governor;

  logic ref_clk = 1'b0;
  logic rst_n;
  always #5 ref_clk = ~ref_clk;

  dvfs_governor_if bus();

  dvfs_governor #(
    .WINDOW_LOG2(4), .UP_THRESH(8'd192), .DOWN_THRESH(8'd64),
    .HOLDOFF_CYCLES(16'd256), .TIMEOUT_CYCLES(16'd4096)
  ) dut (
    .ref_clk(ref_clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  localparam int HOLD = 256;
  localparam int TMO  = 4096;

  int n_err = 0;
  int n_chk = 0;
  int avg_q[$];
  int tgt_q[$];
  int mc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_target(input int c, input int mx, input int avg);
    if (c > mx) return mx;
    if (avg >= 192 && c < mx) return c + 1;
    if (avg <= 64 && c > 0) return c - 1;
    return c;
  endfunction

  task automatic pop_tgt(output int t);
    if (tgt_q.size() == 0) begin
      chk("tgt_q_underflow", 32'd0, 32'd1);
      t = -1;
    end else begin
      t = tgt_q.pop_front();
    end
  endtask

  // 16 samples base+i*step, each followed by gap idle cycles; checks the resulting window_avg
  task automatic send_window(input int base, input int step, input int gap, input bit act);
    int sum;
    int e;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      bus.util_valid  = 1'b1;
      bus.util_sample = 8'(base + i * step);
      sum += (base + i * step) & 255;
      @(negedge ref_clk);
      bus.util_valid  = 1'b0;
      bus.util_sample = 8'hAA;
      repeat (gap) @(negedge ref_clk);
    end
    avg_q.push_back(sum >> 4);
    if (act) tgt_q.push_back(model_target(mc, int'(bus.max_level), sum >> 4));
    e = avg_q.pop_front();
    chk("window_avg", bus.window_avg, e);
  endtask

  function automatic bit cond(input int w);
    case (w)
      0: return bus.volt_req_valid;
      1: return bus.frequency_enable;
      2: return !bus.busy;
      3: return !bus.volt_req_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int w, input int budget, output int n);
    n = 0;
    while (!cond(w) && n < budget) begin
      @(negedge ref_clk);
      n++;
    end
    chk($sformatf("wait_cond%0d", w), cond(w), 1);
  endtask

  task automatic check_reset(input string p);
    chk({p, "_busy"}, bus.busy, 0);
    chk({p, "_vrv"}, bus.volt_req_valid, 0);
    chk({p, "_fe"}, bus.frequency_enable, 0);
    chk({p, "_flr"}, bus.frequency_level_req, 4);
    chk({p, "_vlr"}, bus.volt_level_req, 4);
    chk({p, "_avg"}, bus.window_avg, 0);
    chk({p, "_terr"}, bus.timeout_err, 0);
  endtask

  task automatic pulse_ack();
    bus.volt_ack = 1'b1;
    @(negedge ref_clk);
    bus.volt_ack = 1'b0;
  endtask

  task automatic freq_complete(input int lvl);
    bus.current_frequency_level = 3'(lvl);
    bus.frequency_ready = 1'b1;
    @(negedge ref_clk);
    bus.frequency_ready = 1'b0;
  endtask

  initial begin
    int n;
    int t;
    rst_n = 1'b0;
    bus.governor_enable = 1'b0;
    bus.util_valid = 1'b0;
    bus.util_sample = 8'd0;
    bus.max_level = 3'd7;
    bus.volt_ack = 1'b0;
    bus.frequency_ready = 1'b0;
    bus.current_frequency_level = 3'd4;
    repeat (3) @(negedge ref_clk);
    check_reset("rst");
    rst_n = 1'b1;
    mc = 4;
    bus.governor_enable = 1'b1;

    // Stray ack while idle
    pulse_ack();
    chk("stray_ack_busy", bus.busy, 0);

    // Raise 4 -> 5: voltage first
    send_window(200, 0, 0, 1);
    wait_cond(0, 10, n);
    chk("raise_latency", n, 1);
    pop_tgt(t);
    chk("raise_vlr", bus.volt_level_req, t);
    chk("raise_fe_low", bus.frequency_enable, 0);
    pulse_ack();
    chk("raise_vrv_drop", bus.volt_req_valid, 0);
    chk("raise_fe", bus.frequency_enable, 1);
    chk("raise_flr", bus.frequency_level_req, t);
    bus.current_frequency_level = 3'd4;
    bus.frequency_ready = 1'b1;
    repeat (2) @(negedge ref_clk);
    chk("raise_wrong_level_waits", bus.frequency_enable, 1);
    freq_complete(t);
    mc = t;
    chk("raise_fe_drop", bus.frequency_enable, 0);
    chk("raise_committed", bus.frequency_level_req, mc);
    wait_cond(2, 1000, n);
    chk("raise_holdoff_len", n, HOLD);

    // Lower 5 -> 4: frequency first
    send_window(30, 0, 0, 1);
    wait_cond(1, 10, n);
    pop_tgt(t);
    chk("lower_latency", n, 1);
    chk("lower_flr", bus.frequency_level_req, t);
    chk("lower_vrv_low", bus.volt_req_valid, 0);
    freq_complete(t);
    mc = t;
    chk("lower_fe_drop", bus.frequency_enable, 0);
    chk("lower_vrv", bus.volt_req_valid, 1);
    chk("lower_vlr", bus.volt_level_req, t);
    pulse_ack();
    chk("lower_holdoff_vrv", bus.volt_req_valid, 0);
    chk("lower_holdoff_busy", bus.busy, 1);

    // Window closing during holdoff is discarded (ramp 240..255 -> 247)
    send_window(240, 1, 0, 0);
    wait_cond(2, 1000, n);
    repeat (3) @(negedge ref_clk);
    chk("holdoff_window_dropped", bus.busy, 0);
    chk("holdoff_window_flr", bus.frequency_level_req, mc);

    // Disabled governor: full-scale window, no action
    bus.governor_enable = 1'b0;
    send_window(255, 0, 1, 0);
    repeat (3) @(negedge ref_clk);
    chk("disabled_no_req", bus.busy, 0);
    bus.governor_enable = 1'b1;

    // Back to 5, then cap to 2
    send_window(200, 0, 0, 1);
    wait_cond(0, 10, n);
    pop_tgt(t);
    pulse_ack();
    freq_complete(t);
    mc = t;
    wait_cond(2, 1000, n);
    bus.max_level = 3'd2;
    send_window(250, 0, 2, 1);
    wait_cond(1, 10, n);
    pop_tgt(t);
    chk("cap_flr", bus.frequency_level_req, t);
    chk("cap_vrv_low", bus.volt_req_valid, 0);
    bus.max_level = 3'd7;
    repeat (2) @(negedge ref_clk);
    chk("cap_target_stable", bus.frequency_level_req, t);
    freq_complete(t);
    mc = t;
    chk("cap_vrv", bus.volt_req_valid, 1);
    chk("cap_vlr", bus.volt_level_req, t);
    pulse_ack();
    wait_cond(2, 1000, n);

    // Reset in FREQ_WAIT
    send_window(30, 0, 0, 1);
    wait_cond(1, 10, n);
    pop_tgt(t);
    rst_n = 1'b0;
    @(negedge ref_clk);
    check_reset("midrst");
    rst_n = 1'b1;
    mc = 4;
    bus.current_frequency_level = 3'd4;

    // Raise with no ack -> timeout
    send_window(200, 0, 0, 1);
    wait_cond(0, 10, n);
    pop_tgt(t);
    chk("tmo_vlr", bus.volt_level_req, t);
    wait_cond(3, 5000, n);
    chk("tmo_len", n, TMO);
    chk("tmo_err", bus.timeout_err, 1);
    chk("tmo_fe", bus.frequency_enable, 0);
    chk("tmo_committed", bus.frequency_level_req, mc);
    wait_cond(2, 1000, n);
    chk("tmo_holdoff_len", n, HOLD);
    chk("tmo_sticky", bus.timeout_err, 1);

    rst_n = 1'b0;
    @(negedge ref_clk);
    rst_n = 1'b1;
    chk("tmo_cleared_by_reset", bus.timeout_err, 0);
    chk("scoreboard_drained", avg_q.size() + tgt_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
